// File: rtl/dcache_tag_sweeper.sv
// Sole owner of the dcache tag RAM port: clears every set after reset, runs flush sweeps
// that hand valid+dirty lines to the writeback engine, and passes controller traffic in IDLE.
module dcache_tag_sweeper #(
  parameter int NUM_SETS   = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic                  busy,
  input  logic                  cl_req,
  input  logic [NUM_COL-1:0]    cl_wr_en,
  input  logic [ADDR_WIDTH-1:0] cl_addr,
  input  logic [DATA_WIDTH-1:0] cl_wdata,
  output logic [DATA_WIDTH-1:0] cl_rdata,
  output logic                  cl_gnt,
  output logic                  ram_req,
  output logic [NUM_COL-1:0]    ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  wb_req,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [21:0]           wb_tag,
  input  logic                  wb_ack
);

  typedef enum logic [2:0] {INIT, IDLE, FL_RD, FL_CHK, FL_WB, FL_INV} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(NUM_SETS - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_set_cnt, w_set_cnt_nxt;
  logic                  r_flush_pend, w_flush_pend_nxt;
  logic                  r_flush_ack, w_flush_ack_nxt;
  logic                  r_wb_req, w_wb_req_nxt;
  logic [ADDR_WIDTH-1:0] r_wb_addr, w_wb_addr_nxt;
  logic [21:0]           r_wb_tag, w_wb_tag_nxt;
  logic                  w_last_set;
  logic                  w_line_dirty;
  logic                  w_enter_idle;

  assign w_last_set   = (r_set_cnt == LAST_SET);
  assign w_line_dirty = ram_rdata[23] & ram_rdata[22];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= INIT;
      r_set_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_flush_ack  <= 1'b0;
      r_wb_req     <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_tag     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_set_cnt    <= w_set_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_flush_ack  <= w_flush_ack_nxt;
      r_wb_req     <= w_wb_req_nxt;
      r_wb_addr    <= w_wb_addr_nxt;
      r_wb_tag     <= w_wb_tag_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_set_cnt_nxt    = r_set_cnt;
    w_flush_pend_nxt = r_flush_pend;
    w_wb_req_nxt     = r_wb_req;
    w_wb_addr_nxt    = r_wb_addr;
    w_wb_tag_nxt     = r_wb_tag;
    ram_req          = 1'b0;
    ram_wr_en        = '0;
    ram_addr         = r_set_cnt;
    ram_wdata        = '0;
    cl_gnt           = 1'b0;

    case (r_state)
      INIT: begin
        ram_req   = 1'b1;
        ram_wr_en = '1;
        if (w_last_set) begin
          w_state_nxt   = IDLE;
          w_set_cnt_nxt = '0;
        end else begin
          w_set_cnt_nxt = r_set_cnt + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        cl_gnt    = 1'b1;
        ram_req   = cl_req;
        ram_wr_en = cl_wr_en;
        ram_addr  = cl_addr;
        ram_wdata = cl_wdata;
        if (flush_req) begin
          w_state_nxt   = FL_RD;
          w_set_cnt_nxt = '0;
        end
      end
      FL_RD: begin
        ram_req     = 1'b1;
        w_state_nxt = FL_CHK;
      end
      FL_CHK: begin
        if (w_line_dirty) begin
          w_wb_req_nxt  = 1'b1;
          w_wb_addr_nxt = r_set_cnt;
          w_wb_tag_nxt  = ram_rdata[21:0];
          w_state_nxt   = FL_WB;
        end else begin
          w_state_nxt = FL_INV;
        end
      end
      FL_WB: begin
        if (wb_ack) begin
          w_wb_req_nxt = 1'b0;
          w_state_nxt  = FL_INV;
        end
      end
      FL_INV: begin
        ram_req   = 1'b1;
        ram_wr_en = '1;
        if (w_last_set) begin
          w_state_nxt   = IDLE;
          w_set_cnt_nxt = '0;
        end else begin
          w_state_nxt   = FL_RD;
          w_set_cnt_nxt = r_set_cnt + ADDR_WIDTH'(1);
        end
      end
      default: w_state_nxt = INIT;
    endcase

    // Requests arriving while busy are merged into a single ack on the next IDLE entry.
    w_enter_idle = (r_state != IDLE) && (w_state_nxt == IDLE);
    if ((r_state != IDLE) && flush_req) w_flush_pend_nxt = 1'b1;
    w_flush_ack_nxt = w_enter_idle && ((r_state == FL_INV) || r_flush_pend || flush_req);
    if (w_enter_idle) w_flush_pend_nxt = 1'b0;
  end

  assign busy      = (r_state != IDLE);
  assign cl_rdata  = ram_rdata;
  assign flush_ack = r_flush_ack;
  assign wb_req    = r_wb_req;
  assign wb_addr   = r_wb_addr;
  assign wb_tag    = r_wb_tag;

endmodule

// File: tb/tb_dcache_tag_sweeper.sv
// Scoreboard bench for dcache_tag_sweeper: tag RAM model, set-array reference model,
// and a monitor that checks reads, writebacks and flush acks as the DUT presents them.
module tb_dcache_tag_sweeper;
  localparam int NS = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush_req;
  logic          flush_ack;
  logic          busy;
  logic          cl_req;
  logic [3:0]    cl_wr_en;
  logic [AW-1:0] cl_addr;
  logic [31:0]   cl_wdata;
  logic [31:0]   cl_rdata;
  logic          cl_gnt;
  logic          ram_req;
  logic [3:0]    ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic [21:0]   wb_tag;
  logic          wb_ack;

  dcache_tag_sweeper #(.NUM_SETS(NS)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_ack(flush_ack), .busy(busy),
    .cl_req(cl_req), .cl_wr_en(cl_wr_en), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_rdata(cl_rdata), .cl_gnt(cl_gnt), .ram_req(ram_req), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .wb_req(wb_req),
    .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_ack(wb_ack)
  );

  typedef struct {
    int          addr;
    logic [21:0] tag;
    int          len;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  int          ack_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ref_mem [NS];
  logic [31:0] mem [NS];
  logic        preload;
  bit          rd_issue;
  bit          in_abort;
  bit          ack_idle_val;
  int          ack_delay;
  int          n_tests;
  int          n_fail;
  int          cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Tag RAM: byte-column writes, registered read of the old contents
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NS; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (ram_req) begin
      for (int c = 0; c < 4; c++)
        if (ram_wr_en[c]) mem[ram_addr][c*8 +: 8] <= ram_wdata[c*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  // Writeback engine: acks after ack_delay cycles of wb_req; ack_idle_val otherwise
  initial begin
    int cnt;
    cnt = 0;
    wb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_req) begin
        wb_ack = (cnt >= ack_delay);
        cnt = (cnt >= ack_delay) ? 0 : cnt + 1;
      end else begin
        wb_ack = ack_idle_val;
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    bit      rd_pend;
    bit      wb_prev;
    int      hi_cnt;
    wb_exp_t cur;
    rd_pend = 1'b0;
    wb_prev = 1'b0;
    hi_cnt  = 0;
    cur     = '{-1, 22'h0, 0};
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (rd_q.size() == 0) fail("rd_unexpected", "got read data, required none");
        else check("cl_rdata", cl_rdata, rd_q.pop_front());
      end
      rd_pend = rd_issue;
      if (wb_req && !wb_prev) begin
        hi_cnt = 0;
        if (wb_q.size() == 0) begin
          fail("wb_unexpected", "got wb_req=1, required no writeback");
          cur = '{-1, 22'h0, 0};
        end else begin
          cur = wb_q.pop_front();
        end
      end
      if (wb_req) begin
        check("wb_addr", 32'(wb_addr), 32'(cur.addr));
        check("wb_tag", 32'(wb_tag), 32'(cur.tag));
        hi_cnt++;
      end
      if (!wb_req && wb_prev && !in_abort) check("wb_req_len", 32'(hi_cnt), 32'(cur.len));
      wb_prev = wb_req;
      if (flush_ack) begin
        if (ack_q.size() == 0) fail("ack_unexpected", "got flush_ack=1, required 0");
        else check("flush_ack_cycle", 32'(cyc), 32'(ack_q.pop_front()));
      end
    end
  end

  task automatic cl_op(input int addr, input logic [3:0] we, input logic [31:0] d);
    cl_req   = 1'b1;
    cl_addr  = addr[AW-1:0];
    cl_wr_en = we;
    cl_wdata = d;
    rd_issue = (we == 4'h0);
    if (we == 4'h0) rd_q.push_back(ref_mem[addr]);
    else for (int c = 0; c < 4; c++) if (we[c]) ref_mem[addr][c*8 +: 8] = d[c*8 +: 8];
    @(negedge clk);
    check("cl_gnt", 32'(cl_gnt), 32'd1);
    check("pass_req", 32'(ram_req), 32'd1);
    check("pass_wr_en", 32'(ram_wr_en), 32'(we));
    check("pass_addr", 32'(ram_addr), 32'(addr));
    check("pass_wdata", ram_wdata, d);
    @(posedge clk);
    #1;
    cl_req   = 1'b0;
    cl_wr_en = 4'h0;
    rd_issue = 1'b0;
  endtask

  task automatic read_all();
    for (int s = 0; s < NS; s++) cl_op(s, 4'h0, 32'h0);
  endtask

  // Called #1 after the posedge that releases reset; controller noise must be ignored
  task automatic init_sweep(input int flush_at);
    for (int i = 0; i < NS; i++) begin
      cl_req    = 1'b1;
      cl_wr_en  = 4'($urandom);
      cl_addr   = AW'($urandom);
      cl_wdata  = $urandom;
      flush_req = (i == flush_at);
      @(negedge clk);
      check("init_busy", 32'(busy), 32'd1);
      check("init_gnt", 32'(cl_gnt), 32'd0);
      check("init_req", 32'(ram_req), 32'd1);
      check("init_wr_en", 32'(ram_wr_en), 32'hF);
      check("init_addr", 32'(ram_addr), 32'(i));
      check("init_wdata", ram_wdata, 32'h0);
      @(posedge clk);
      #1;
    end
    cl_req    = 1'b0;
    cl_wr_en  = 4'h0;
    flush_req = 1'b0;
    for (int s = 0; s < NS; s++) ref_mem[s] = 32'h0;
    @(negedge clk);
    check("init_done_busy", 32'(busy), 32'd0);
    check("init_done_gnt", 32'(cl_gnt), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) fail("idle_timeout", "got busy=1 after cycle budget, required 0");
  endtask

  task automatic do_flush(input int delay, input bit idle_ack, input bit with_wr, input bit mid_req);
    int extra;
    extra = 0;
    if (with_wr) begin
      cl_req   = 1'b1;
      cl_wr_en = 4'hF;
      cl_addr  = AW'(15);
      cl_wdata = 32'h0081_2345;
      ref_mem[15] = 32'h0081_2345;
    end
    for (int s = 0; s < NS; s++)
      if (ref_mem[s][23] && ref_mem[s][22]) begin
        wb_q.push_back('{s, ref_mem[s][21:0], delay + 1});
        extra += delay + 1;
      end
    ack_delay    = delay;
    ack_idle_val = idle_ack;
    ack_q.push_back(cyc + 1 + 3 * NS + extra);
    flush_req = 1'b1;
    @(negedge clk);
    if (with_wr) begin
      check("flush_cycle_gnt", 32'(cl_gnt), 32'd1);
      check("flush_cycle_wr", 32'(ram_wr_en), 32'hF);
      check("flush_cycle_addr", 32'(ram_addr), 32'd15);
    end
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    cl_req    = 1'b0;
    cl_wr_en  = 4'h0;
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_gnt", 32'(cl_gnt), 32'd0);
    if (mid_req) begin
      repeat (7) @(posedge clk);
      #1;
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
    end
    wait_idle(3000);
    for (int s = 0; s < NS; s++) ref_mem[s] = 32'h0;
    check("flush_done_gnt", 32'(cl_gnt), 32'd1);
    read_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    preload = 1'b1;
    flush_req = 1'b0;
    cl_req = 1'b0;
    cl_wr_en = 4'h0;
    cl_addr = '0;
    cl_wdata = 32'h0;
    rd_issue = 1'b0;
    in_abort = 1'b0;
    ack_delay = 0;
    ack_idle_val = 1'b0;
    for (int s = 0; s < NS; s++) ref_mem[s] = 32'hFFFF_FFFF;

    // Reset state, then the power-on clear of a preloaded RAM
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_gnt", 32'(cl_gnt), 32'd0);
    check("rst_wb_req", 32'(wb_req), 32'd0);
    check("rst_flush_ack", 32'(flush_ack), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    preload = 1'b0;
    init_sweep(-1);
    read_all();

    // IDLE pass-through, full and partial column writes
    cl_op(3, 4'hF, 32'h00C0_0ABC);
    cl_op(3, 4'h0, 32'h0);
    cl_op(3, 4'b0001, 32'hFFFF_FF11);
    cl_op(3, 4'h0, 32'h0);
    cl_op(3, 4'hF, 32'h0);

    // One dirty line, ack always high, controller write granted in the flush cycle
    cl_op(5, 4'hF, 32'h00C1_2345);
    do_flush(0, 1'b1, 1'b1, 1'b0);

    // Same lines, writeback ack delayed by 10 cycles
    cl_op(5, 4'hF, 32'h00C1_2345);
    cl_op(15, 4'hF, 32'h0081_2345);
    do_flush(10, 1'b0, 1'b0, 1'b0);

    // Random contents and random ack latency; round 1 also repeats flush_req mid-sweep
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 24; k++) begin
        w = $urandom_range(0, 3);
        cl_op($urandom_range(0, NS - 1), (w == 0) ? 4'h0 : 4'($urandom), $urandom);
      end
      do_flush($urandom_range(0, 3), 1'($urandom), 1'b0, r == 1);
    end

    // Reset while the sweep waits on set 8's writeback
    cl_op(8, 4'hF, 32'h00C0_0888);
    wb_q.push_back('{8, 22'h000888, 41});
    ack_delay = 40;
    ack_idle_val = 1'b0;
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    w = 0;
    while (!(wb_req && wb_addr == AW'(8)) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!(wb_req && wb_addr == AW'(8))) fail("abort_wait", "got no wb_req for set 8, required one");
    repeat (3) @(posedge clk);
    @(posedge clk);
    #3;
    in_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_wb_req", 32'(wb_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_gnt", 32'(cl_gnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    wb_q.delete();
    rst_n = 1'b1;
    init_sweep(-1);
    in_abort = 1'b0;
    read_all();

    // Flush request during INIT: acked on the first IDLE cycle, no sweep
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_q.push_back(cyc + NS);
    init_sweep(3);
    for (int k = 0; k < 3; k++) begin
      check("post_init_flush_idle", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    @(posedge clk);
    #1;
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
